// File: rtl/uc_multiciclo_if.sv
// Control/status bundle between the multicycle control unit and the datapath.
// The master side is the control unit; the slave side is the datapath/console.
interface uc_multiciclo_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic             z;
  logic             run;
  logic             step;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       Op;
  logic             pc_en;
  logic             ir_en;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  Opcode, z, run, step,
    output s_inc, s_inm, we3, wez, Op, pc_en, ir_en, halted, instr_cnt
  );

  modport slave (
    output Opcode, z, run, step,
    input  s_inc, s_inm, we3, wez, Op, pc_en, ir_en, halted, instr_cnt
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the 8-bit microcontroller: FETCH/EXEC/WB sequencing,
// run/pause/single-step control, HALT and a retired-instruction counter.
module uc_multiciclo #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  uc_multiciclo_if.master  bus
);

  typedef enum logic [2:0] {PAUSE, FETCH, EXEC, WB, HALT} state_t;
  typedef enum logic [2:0] {K_ALU, K_LI, K_HALT, K_J, K_JZ, K_JNZ, K_NOP} kind_t;

  state_t           state, state_nxt;
  kind_t            kind;
  logic             stepping, stepping_nxt;
  logic             step_q;
  logic             step_rise;
  logic             retire;
  logic [CNT_W-1:0] cnt;

  logic       s_inc, s_inm, we3, wez, pc_en, ir_en;
  logic [2:0] op;

  always_comb begin
    kind = K_NOP;
    if (bus.Opcode[5])
      kind = K_ALU;
    else if (bus.Opcode[4:2] == 3'b001)
      kind = K_LI;
    else begin
      case (bus.Opcode)
        6'b000000: kind = K_HALT;
        6'b000001: kind = K_J;
        6'b000010: kind = K_JZ;
        6'b000011: kind = K_JNZ;
        default:   kind = K_NOP;
      endcase
    end
  end

  // Only a fresh step edge starts an instruction, so a held step runs exactly one.
  assign step_rise = bus.step && !step_q;

  always_comb begin
    state_nxt    = state;
    stepping_nxt = stepping;
    retire       = 1'b0;
    s_inc        = 1'b1;
    s_inm        = 1'b0;
    we3          = 1'b0;
    wez          = 1'b0;
    op           = 3'b000;
    pc_en        = 1'b0;
    ir_en        = 1'b0;
    case (state)
      PAUSE: begin
        if (bus.run) begin
          state_nxt    = FETCH;
          stepping_nxt = 1'b0;
        end else if (bus.step && step_rise) begin
          state_nxt    = FETCH;
          stepping_nxt = 1'b1;
        end
      end
      FETCH: begin
        ir_en     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        case (kind)
          K_ALU: begin
            op        = bus.Opcode[4:2];
            state_nxt = WB;
          end
          K_LI: begin
            s_inm     = 1'b1;
            state_nxt = WB;
          end
          K_HALT: state_nxt = HALT;
          K_J: begin
            s_inc  = 1'b0;
            pc_en  = 1'b1;
            retire = 1'b1;
          end
          K_JZ: begin
            s_inc  = ~bus.z;
            pc_en  = 1'b1;
            retire = 1'b1;
          end
          K_JNZ: begin
            s_inc  = bus.z;
            pc_en  = 1'b1;
            retire = 1'b1;
          end
          default: begin
            pc_en  = 1'b1;
            retire = 1'b1;
          end
        endcase
      end
      WB: begin
        if (kind == K_ALU) begin
          op  = bus.Opcode[4:2];
          wez = 1'b1;
        end else begin
          s_inm = 1'b1;
        end
        we3    = 1'b1;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = PAUSE;
    endcase
    // Instruction boundary: keep going only when free-running and not single-stepping.
    if (retire) begin
      state_nxt    = (bus.run && !stepping) ? FETCH : PAUSE;
      stepping_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PAUSE;
      stepping <= 1'b0;
      step_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      stepping <= stepping_nxt;
      step_q   <= bus.step;
      if (pc_en)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.s_inc     = s_inc;
  assign bus.s_inm     = s_inm;
  assign bus.we3       = we3;
  assign bus.wez       = wez;
  assign bus.Op        = op;
  assign bus.pc_en     = pc_en;
  assign bus.ir_en     = ir_en;
  assign bus.halted    = (state == HALT);
  assign bus.instr_cnt = cnt;

  a_fetch_excl: assert property (@(posedge clk) disable iff (reset) !(ir_en && pc_en));
  a_write_retires: assert property (@(posedge clk) disable iff (reset) we3 |-> pc_en);
  a_halt_quiet: assert property (@(posedge clk) disable iff (reset)
    bus.halted |-> !(pc_en || ir_en || we3 || wez));

endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomized bench for uc_multiciclo with an instruction-level expected-cycle model.
module tb_uc_multiciclo;
  localparam int CNT_W = 4;
  localparam logic [9:0] IDLE_W   = 10'b1000000000;
  localparam logic [9:0] FETCH_W  = 10'b1000000010;
  localparam logic [9:0] HALTED_W = 10'b1000000001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uc_multiciclo_if #(.CNT_W(CNT_W)) bus();
  uc_multiciclo #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int compares = 0;
  int fails = 0;
  int model_cnt = 0;
  logic [9:0]       obs_w [16];
  logic [CNT_W-1:0] obs_c [16];
  logic [9:0]       outs;

  // {s_inc, s_inm, we3, wez, Op, pc_en, ir_en, halted}
  assign outs = {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.Op, bus.pc_en, bus.ir_en, bus.halted};

  function automatic logic [9:0] pk(input logic si, input logic sm, input logic w3, input logic wz,
                                    input logic [2:0] op, input logic pc);
    return {si, sm, w3, wz, op, pc, 1'b0, 1'b0};
  endfunction

  // Expected output word for each cycle of one instruction, starting with its fetch cycle.
  function automatic int model_instr(input logic [5:0] opc, input logic zz, output logic [2:0][9:0] seq);
    logic [2:0] aop;
    aop = opc[4:2];
    seq = '0;
    seq[0] = FETCH_W;
    if (opc[5]) begin
      seq[1] = pk(1'b1, 1'b0, 1'b0, 1'b0, aop, 1'b0);
      seq[2] = pk(1'b1, 1'b0, 1'b1, 1'b1, aop, 1'b1);
      return 3;
    end
    if (opc[5:2] == 4'b0001) begin
      seq[1] = pk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      seq[2] = pk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
      return 3;
    end
    case (opc)
      6'd0:    seq[1] = IDLE_W;
      6'd1:    seq[1] = pk(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      6'd2:    seq[1] = pk(!zz, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      6'd3:    seq[1] = pk(zz, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      default: seq[1] = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    endcase
    return 2;
  endfunction

  // Record n cycles of outputs at the falling edge; returns 1 ns after a rising edge.
  task automatic sample(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_w[i] = outs;
      obs_c[i] = bus.instr_cnt;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.run = 1'b0; bus.step = 1'b0; bus.Opcode = 6'b100100; bus.z = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compares++;
    if (outs !== IDLE_W || bus.instr_cnt !== '0) begin
      fails++; $display("FAIL reset_held outs=%b cnt=%0d want %b cnt=0", outs, bus.instr_cnt, IDLE_W);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 0;
    sample(10);
    for (int i = 0; i < 10; i++) begin
      compares++;
      if (obs_w[i] !== IDLE_W || obs_c[i] !== '0) begin
        fails++; $display("FAIL reset_idle cyc%0d outs=%b cnt=%0d want %b cnt=0", i, obs_w[i], obs_c[i], IDLE_W);
      end
    end
  endtask

  task automatic test_alu;
    logic [2:0][9:0] seq;
    int len;
    bus.Opcode = 6'b100100;
    len = model_instr(bus.Opcode, bus.z, seq);
    bus.run = 1'b1;
    sample(5);
    compares++;
    if (obs_w[0] !== IDLE_W) begin fails++; $display("FAIL alu_pause got %b want %b", obs_w[0], IDLE_W); end
    for (int i = 0; i < len; i++) begin
      compares++;
      if (obs_w[1+i] !== seq[i] || obs_c[1+i] !== model_cnt[CNT_W-1:0]) begin
        fails++; $display("FAIL alu cyc%0d outs=%b cnt=%0d want %b cnt=%0d", i, obs_w[1+i], obs_c[1+i], seq[i], model_cnt[CNT_W-1:0]);
      end
      if (seq[i][2]) model_cnt++;
    end
    compares++;
    if (obs_w[4] !== FETCH_W || obs_c[4] !== model_cnt[CNT_W-1:0]) begin
      fails++; $display("FAIL alu_refetch outs=%b cnt=%0d want %b cnt=%0d", obs_w[4], obs_c[4], FETCH_W, model_cnt[CNT_W-1:0]);
    end
    // run drops after the second fetch: this instruction finishes, then pause
    bus.run = 1'b0;
    sample(3);
    for (int i = 1; i < 4; i++) begin
      compares++;
      if (obs_w[i-1] !== ((i < 3) ? seq[i] : IDLE_W)) begin
        fails++; $display("FAIL run_drop cyc%0d got %b want %b", i, obs_w[i-1], (i < 3) ? seq[i] : IDLE_W);
      end
      if (i < 3 && seq[i][2]) model_cnt++;
    end
  endtask

  task automatic run_list(input string name, input logic [5:0] opcs [], input logic zs []);
    logic [2:0][9:0] seq;
    int len;
    bus.run = 1'b1;
    sample(1);
    compares++;
    if (obs_w[0] !== IDLE_W) begin fails++; $display("FAIL %s_start got %b want %b", name, obs_w[0], IDLE_W); end
    for (int k = 0; k < opcs.size(); k++) begin
      bus.Opcode = opcs[k];
      bus.z = zs[k];
      if (k == opcs.size() - 1) bus.run = 1'b0;
      len = model_instr(opcs[k], zs[k], seq);
      sample(len);
      for (int i = 0; i < len; i++) begin
        compares++;
        if (obs_w[i] !== seq[i] || obs_c[i] !== model_cnt[CNT_W-1:0]) begin
          fails++;
          $display("FAIL %s op=%b z=%b cyc%0d outs=%b cnt=%0d want %b cnt=%0d", name, opcs[k], zs[k], i,
                   obs_w[i], obs_c[i], seq[i], model_cnt[CNT_W-1:0]);
        end
        if (seq[i][2]) model_cnt++;
      end
    end
    sample(1);
    compares++;
    if (obs_w[0] !== IDLE_W || obs_c[0] !== model_cnt[CNT_W-1:0]) begin
      fails++; $display("FAIL %s_end outs=%b cnt=%0d want %b cnt=%0d", name, obs_w[0], obs_c[0], IDLE_W, model_cnt[CNT_W-1:0]);
    end
  endtask

  task automatic test_branches;
    logic [5:0] opcs [] = '{6'd2, 6'd2, 6'd3, 6'd3, 6'd1, 6'b010000};
    logic       zs   [] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    run_list("branch", opcs, zs);
  endtask

  task automatic test_random;
    logic [5:0] opcs [];
    logic       zs   [];
    opcs = new[40];
    zs = new[40];
    for (int k = 0; k < 40; k++) begin
      do opcs[k] = 6'($urandom); while (opcs[k] == 6'd0);
      zs[k] = 1'($urandom);
    end
    run_list("random", opcs, zs);
  endtask

  task automatic test_step_li;
    logic [2:0][9:0] seq;
    logic [9:0] want;
    int len;
    bus.run = 1'b0;
    bus.Opcode = 6'b000100;
    len = model_instr(bus.Opcode, bus.z, seq);
    bus.step = 1'b1;
    sample(1);
    bus.step = 1'b0;
    sample(5);
    for (int i = 0; i < 5; i++) begin
      want = (i < len) ? seq[i] : IDLE_W;
      compares++;
      if (obs_w[i] !== want) begin fails++; $display("FAIL step_pulse cyc%0d got %b want %b", i, obs_w[i], want); end
      if (want[2]) model_cnt++;
    end
    // step held for five cycles still retires a single instruction
    bus.step = 1'b1;
    sample(5);
    for (int i = 0; i < 5; i++) begin
      want = (i >= 1 && i <= len) ? seq[i-1] : IDLE_W;
      compares++;
      if (obs_w[i] !== want) begin fails++; $display("FAIL step_held cyc%0d got %b want %b", i, obs_w[i], want); end
      if (want[2]) model_cnt++;
    end
    bus.step = 1'b0;
    sample(3);
    for (int i = 0; i < 3; i++) begin
      compares++;
      if (obs_w[i] !== IDLE_W || obs_c[i] !== model_cnt[CNT_W-1:0]) begin
        fails++; $display("FAIL step_after cyc%0d outs=%b cnt=%0d want %b cnt=%0d", i, obs_w[i], obs_c[i], IDLE_W, model_cnt[CNT_W-1:0]);
      end
    end
  endtask

  task automatic test_halt;
    logic [2:0][9:0] seq;
    int len;
    bus.Opcode = 6'b000000;
    len = model_instr(bus.Opcode, bus.z, seq);
    bus.run = 1'b1;
    sample(1 + len);
    for (int i = 0; i < len; i++) begin
      compares++;
      if (obs_w[1+i] !== seq[i]) begin fails++; $display("FAIL halt_seq cyc%0d got %b want %b", i, obs_w[1+i], seq[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      bus.run = 1'($urandom);
      bus.step = 1'($urandom);
      sample(1);
      compares++;
      if (obs_w[0] !== HALTED_W || obs_c[0] !== model_cnt[CNT_W-1:0]) begin
        fails++; $display("FAIL halt_hold cyc%0d outs=%b cnt=%0d want %b cnt=%0d", i, obs_w[0], obs_c[0], HALTED_W, model_cnt[CNT_W-1:0]);
      end
    end
    reset = 1'b1;
    #1;
    compares++;
    if (outs !== IDLE_W || bus.instr_cnt !== '0) begin
      fails++; $display("FAIL halt_reset outs=%b cnt=%0d want %b cnt=0", outs, bus.instr_cnt, IDLE_W);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    model_cnt = 0;
    sample(2);
    compares++;
    if (obs_w[1] !== IDLE_W || obs_c[1] !== '0) begin
      fails++; $display("FAIL halt_released outs=%b cnt=%0d want %b cnt=0", obs_w[1], obs_c[1], IDLE_W);
    end
  endtask

  task automatic test_reset_mid_wb;
    logic [2:0][9:0] seq;
    int len;
    bus.Opcode = {1'b1, 3'($urandom), 2'b01};
    len = model_instr(bus.Opcode, bus.z, seq);
    bus.run = 1'b1;
    sample(3);
    @(negedge clk);
    compares++;
    if (outs !== seq[2]) begin fails++; $display("FAIL wb_before_reset got %b want %b", outs, seq[2]); end
    #1 reset = 1'b1;
    #1;
    compares++;
    if (outs !== IDLE_W || bus.instr_cnt !== '0) begin
      fails++; $display("FAIL wb_reset outs=%b cnt=%0d want %b cnt=0", outs, bus.instr_cnt, IDLE_W);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.run = 1'b0;
    model_cnt = 0;
    sample(2);
    compares++;
    if (obs_w[1] !== IDLE_W || obs_c[1] !== '0) begin
      fails++; $display("FAIL wb_reset_after outs=%b cnt=%0d want %b cnt=0", obs_w[1], obs_c[1], IDLE_W);
    end
  endtask

  task automatic test_wrap;
    logic [5:0] opcs [];
    logic       zs   [];
    opcs = new[16];
    zs = new[16];
    for (int k = 0; k < 16; k++) begin opcs[k] = 6'b010000; zs[k] = 1'b0; end
    model_cnt = 0;
    run_list("wrap", opcs, zs);
    compares++;
    if (bus.instr_cnt !== '0) begin fails++; $display("FAIL wrap_zero got %0d want 0", bus.instr_cnt); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branches;
    test_step_li;
    test_random;
    test_halt;
    test_reset_mid_wb;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
